// File: rtl/l2_arbiter_if.sv
// Bundle of the L1-side and L2-side signals around the L2 arbiter.
// Handshake: a client holds its read/write request until it sees a one-cycle resp pulse.
// The L2 strobe is held until l2_resp. Data on the rdata lines is valid with resp/l2_resp.
interface l2_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    logic [ADDR_WIDTH-1:0] icache_address;
    logic                  icache_read;
    logic [LINE_WIDTH-1:0] icache_rdata;
    logic                  icache_resp;

    logic [ADDR_WIDTH-1:0] dcache_address;
    logic [LINE_WIDTH-1:0] dcache_wdata;
    logic                  dcache_read;
    logic                  dcache_write;
    logic [LINE_WIDTH-1:0] dcache_rdata;
    logic                  dcache_resp;

    logic [ADDR_WIDTH-1:0] l2_address;
    logic [LINE_WIDTH-1:0] l2_wdata;
    logic                  l2_read;
    logic                  l2_write;
    logic [LINE_WIDTH-1:0] l2_rdata;
    logic                  l2_resp;

    modport slave (
        input  icache_address, icache_read,
        input  dcache_address, dcache_wdata, dcache_read, dcache_write,
        input  l2_rdata, l2_resp,
        output icache_rdata, icache_resp, dcache_rdata, dcache_resp,
        output l2_address, l2_wdata, l2_read, l2_write
    );

    modport master (
        output icache_address, icache_read,
        output dcache_address, dcache_wdata, dcache_read, dcache_write,
        output l2_rdata, l2_resp,
        input  icache_rdata, icache_resp, dcache_rdata, dcache_resp,
        input  l2_address, l2_wdata, l2_read, l2_write
    );
endinterface

// File: rtl/l2_arbiter.sv
// Two-client (I-cache / D-cache) arbiter in front of the L2 cache; one transaction at a time,
// request captured at grant, all outputs registered.
module l2_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int LINE_WIDTH     = 128,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic       clk,
    input  logic       reset,
    l2_arbiter_if.slave bus,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE_I = 2'd1, SERVE_D = 2'd2, RESP = 2'd3} state_t;

    state_t state, state_next;
    logic   last_grant_d, last_grant_d_next;
    logic   i_req, d_req, grant_i, grant_d;

    logic [ADDR_WIDTH-1:0] l2_address_next;
    logic [LINE_WIDTH-1:0] l2_wdata_next, icache_rdata_next, dcache_rdata_next;
    logic                  l2_read_next, l2_write_next, icache_resp_next, dcache_resp_next;

    assign state_dbg = state;

    // On conflict D wins unless round-robin says I is owed the slot.
    always_comb begin
        i_req   = bus.icache_read;
        d_req   = bus.dcache_read | bus.dcache_write;
        grant_d = d_req && (!i_req || (FIXED_PRIORITY != 0) || !last_grant_d);
        grant_i = i_req && !grant_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
        end else begin
            state        <= state_next;
            last_grant_d <= last_grant_d_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_d)      state_next = SERVE_D;
                else if (grant_i) state_next = SERVE_I;
            end
            SERVE_I, SERVE_D: if (bus.l2_resp) state_next = RESP;
            RESP:             state_next = IDLE;
            default:          state_next = IDLE;
        endcase
    end

    always_comb begin
        l2_address_next   = bus.l2_address;
        l2_wdata_next     = bus.l2_wdata;
        l2_read_next      = bus.l2_read;
        l2_write_next     = bus.l2_write;
        icache_rdata_next = bus.icache_rdata;
        dcache_rdata_next = bus.dcache_rdata;
        icache_resp_next  = 1'b0;
        dcache_resp_next  = 1'b0;
        last_grant_d_next = last_grant_d;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    // A simultaneous read+write is treated as a write.
                    l2_address_next   = {bus.dcache_address[ADDR_WIDTH-1:4], 4'h0};
                    l2_write_next     = bus.dcache_write;
                    l2_read_next      = !bus.dcache_write;
                    if (bus.dcache_write) l2_wdata_next = bus.dcache_wdata;
                    last_grant_d_next = 1'b1;
                end else if (grant_i) begin
                    l2_address_next   = {bus.icache_address[ADDR_WIDTH-1:4], 4'h0};
                    l2_read_next      = 1'b1;
                    l2_write_next     = 1'b0;
                    last_grant_d_next = 1'b0;
                end
            end
            SERVE_I: begin
                if (bus.l2_resp) begin
                    l2_read_next      = 1'b0;
                    l2_write_next     = 1'b0;
                    icache_rdata_next = bus.l2_rdata;
                    icache_resp_next  = 1'b1;
                end
            end
            SERVE_D: begin
                if (bus.l2_resp) begin
                    l2_read_next      = 1'b0;
                    l2_write_next     = 1'b0;
                    dcache_rdata_next = bus.l2_rdata;
                    dcache_resp_next  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.l2_address   <= '0;
            bus.l2_wdata     <= '0;
            bus.l2_read      <= 1'b0;
            bus.l2_write     <= 1'b0;
            bus.icache_rdata <= '0;
            bus.dcache_rdata <= '0;
            bus.icache_resp  <= 1'b0;
            bus.dcache_resp  <= 1'b0;
        end else begin
            bus.l2_address   <= l2_address_next;
            bus.l2_wdata     <= l2_wdata_next;
            bus.l2_read      <= l2_read_next;
            bus.l2_write     <= l2_write_next;
            bus.icache_rdata <= icache_rdata_next;
            bus.dcache_rdata <= dcache_rdata_next;
            bus.icache_resp  <= icache_resp_next;
            bus.dcache_resp  <= dcache_resp_next;
        end
    end
endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: round-robin instance (sel=0) and fixed-priority instance (sel=1),
// with a request queue and a response queue filled as stimulus is driven.
module tb_l2_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic sel;

  logic [AW-1:0] icache_address, dcache_address;
  logic          icache_read, dcache_read, dcache_write, l2_resp;
  logic [LW-1:0] dcache_wdata, l2_rdata;
  logic [1:0]    state0, state1;

  l2_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus0 ();
  l2_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus1 ();

  assign bus0.icache_address = icache_address;
  assign bus0.dcache_address = dcache_address;
  assign bus0.dcache_wdata   = dcache_wdata;
  assign bus0.l2_rdata       = l2_rdata;
  assign bus0.icache_read    = !sel && icache_read;
  assign bus0.dcache_read    = !sel && dcache_read;
  assign bus0.dcache_write   = !sel && dcache_write;
  assign bus0.l2_resp        = !sel && l2_resp;
  assign bus1.icache_address = icache_address;
  assign bus1.dcache_address = dcache_address;
  assign bus1.dcache_wdata   = dcache_wdata;
  assign bus1.l2_rdata       = l2_rdata;
  assign bus1.icache_read    = sel && icache_read;
  assign bus1.dcache_read    = sel && dcache_read;
  assign bus1.dcache_write   = sel && dcache_write;
  assign bus1.l2_resp        = sel && l2_resp;

  l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .FIXED_PRIORITY(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .state_dbg(state0));
  l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .FIXED_PRIORITY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .state_dbg(state1));

  logic [AW-1:0] o_l2_address;
  logic [LW-1:0] o_l2_wdata, o_icache_rdata, o_dcache_rdata;
  logic          o_l2_read, o_l2_write, o_icache_resp, o_dcache_resp;
  logic [1:0]    o_state;

  always_comb begin
    o_l2_address   = sel ? bus1.l2_address   : bus0.l2_address;
    o_l2_wdata     = sel ? bus1.l2_wdata     : bus0.l2_wdata;
    o_l2_read      = sel ? bus1.l2_read      : bus0.l2_read;
    o_l2_write     = sel ? bus1.l2_write     : bus0.l2_write;
    o_icache_rdata = sel ? bus1.icache_rdata : bus0.icache_rdata;
    o_dcache_rdata = sel ? bus1.dcache_rdata : bus0.dcache_rdata;
    o_icache_resp  = sel ? bus1.icache_resp  : bus0.icache_resp;
    o_dcache_resp  = sel ? bus1.dcache_resp  : bus0.dcache_resp;
    o_state        = sel ? state1            : state0;
  end

  // ---------------- scoreboard ----------------
  logic [145:0] req_q[$];   // {l2_address, l2_read, l2_write, l2_wdata}
  logic [128:0] resp_q[$];  // {served_is_d, rdata}
  logic         model_last_d;
  logic [LW-1:0] model_wdata, last_rdata_i, last_rdata_d;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return {a[AW-1:4], 4'h0};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- drivers ----------------
  task automatic req_i(input logic [AW-1:0] a);
    icache_address = a;
    icache_read    = 1'b1;
  endtask

  task automatic req_d(input logic [AW-1:0] a, input logic rd, input logic wr, input logic [LW-1:0] wd);
    dcache_address = a;
    dcache_read    = rd;
    dcache_write   = wr;
    dcache_wdata   = wd;
  endtask

  task automatic push_i(input logic [AW-1:0] a);
    req_q.push_back({align(a), 1'b1, 1'b0, model_wdata});
    model_last_d = 1'b0;
  endtask

  task automatic push_d(input logic [AW-1:0] a, input logic wr, input logic [LW-1:0] wd);
    if (wr) model_wdata = wd;
    req_q.push_back({align(a), !wr, wr, model_wdata});
    model_last_d = 1'b1;
  endtask

  // Acts as the L2 for one transaction and as the served client's response checker.
  task automatic serve(input logic is_d, input int lat, input logic [LW-1:0] data, input int exp_wait);
    int w;
    logic [145:0] e;
    logic [128:0] r;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(o_l2_read || o_l2_write) && w < 50);
    if (!(o_l2_read || o_l2_write)) begin
      check("strobe_timeout", 160'(0), 160'(1));
      return;
    end
    if (exp_wait > 0) check("grant_wait", 160'(w), 160'(exp_wait));
    if (req_q.size() == 0) begin
      check("req_q_empty", 160'(0), 160'(1));
      return;
    end
    e = req_q.pop_front();
    check("l2_address", 160'(o_l2_address), 160'(e[145:130]));
    check("l2_read",    160'(o_l2_read),    160'(e[129]));
    check("l2_write",   160'(o_l2_write),   160'(e[128]));
    check("l2_wdata",   160'(o_l2_wdata),   160'(e[127:0]));
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      check("strobe_hold", 160'({o_l2_read, o_l2_write, o_l2_address}),
            160'({e[129], e[128], e[145:130]}));
    end
    l2_resp  = 1'b1;
    l2_rdata = data;
    resp_q.push_back({is_d, data});
    @(negedge clk);
    l2_resp  = 1'b0;
    l2_rdata = rand_line();
    r = resp_q.pop_front();
    check("icache_resp", 160'(o_icache_resp), 160'(!r[128]));
    check("dcache_resp", 160'(o_dcache_resp), 160'(r[128]));
    if (r[128]) begin
      check("dcache_rdata", 160'(o_dcache_rdata), 160'(r[127:0]));
      last_rdata_d = r[127:0];
      dcache_read  = 1'b0;
      dcache_write = 1'b0;
    end else begin
      check("icache_rdata", 160'(o_icache_rdata), 160'(r[127:0]));
      last_rdata_i = r[127:0];
      icache_read  = 1'b0;
    end
    check("strobe_clear", 160'({o_l2_read, o_l2_write}), 160'(0));
    check("state_resp", 160'(o_state), 160'(3));
    @(negedge clk);
    check("resp_single", 160'({o_icache_resp, o_dcache_resp}), 160'(0));
    check("state_idle", 160'(o_state), 160'(0));
  endtask

  // Both clients request together; the expected winner comes from the bench's own last-grant model.
  task automatic conflict(input logic [AW-1:0] ai, input logic [AW-1:0] ad, input logic rd,
                          input logic wr, input logic [LW-1:0] wd, input int lat);
    req_i(ai);
    req_d(ad, rd, wr, wd);
    if (sel || !model_last_d) begin
      push_d(ad, wr, wd);
      push_i(ai);
      serve(1'b1, lat, rand_line(), 1);
      serve(1'b0, lat, rand_line(), 1);
    end else begin
      push_i(ai);
      push_d(ad, wr, wd);
      serve(1'b0, lat, rand_line(), 1);
      serve(1'b1, lat, rand_line(), 1);
    end
  endtask

  task automatic clear_inputs();
    icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0; l2_resp = 1'b0;
    icache_address = '0; dcache_address = '0; dcache_wdata = '0; l2_rdata = '0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    reset = 1'b1;
    sel   = 1'b0;
    clear_inputs();
    model_last_d = 1'b0; model_wdata = '0; last_rdata_i = '0; last_rdata_d = '0;
    repeat (2) @(negedge clk);
    check("rst_strobes", 160'({o_l2_read, o_l2_write, o_icache_resp, o_dcache_resp}), 160'(0));
    check("rst_address", 160'(o_l2_address), 160'(0));
    check("rst_wdata",   160'(o_l2_wdata),   160'(0));
    check("rst_rdata",   160'({o_icache_rdata[31:0], o_dcache_rdata[31:0]}), 160'(0));
    check("rst_state",   160'(o_state), 160'(0));
    reset = 1'b0;

    // conflicts from reset: D first, then I; repeat conflict goes to D again
    conflict(16'h3004, 16'h2008, 1'b1, 1'b0, '0, 2);
    conflict(16'h3104, 16'h2108, 1'b0, 1'b1, rand_line(), 1);

    // I-only read with l2_resp three cycles in
    req_i(16'h1234);
    push_i(16'h1234);
    serve(1'b0, 3, {16{8'hA5}}, 1);

    // D write
    req_d(16'h00F7, 1'b0, 1'b1, 128'h0123456789ABCDEF0123456789ABCDEF);
    push_d(16'h00F7, 1'b1, 128'h0123456789ABCDEF0123456789ABCDEF);
    serve(1'b1, 2, rand_line(), 1);

    // illegal read+write behaves as a write
    req_d(16'hBEEF, 1'b1, 1'b1, {4{32'hCAFE_F00D}});
    push_d(16'hBEEF, 1'b1, {4{32'hCAFE_F00D}});
    serve(1'b1, 1, rand_line(), 1);

    // stray l2_resp in IDLE is ignored and rdata registers hold
    l2_resp  = 1'b1;
    l2_rdata = {4{32'h5A5A_1234}};
    @(negedge clk);
    l2_resp = 1'b0;
    check("stray_no_resp", 160'({o_icache_resp, o_dcache_resp, o_l2_read, o_l2_write}), 160'(0));
    check("stray_state",   160'(o_state), 160'(0));
    @(negedge clk);
    check("stray_hold_i", 160'(o_icache_rdata), 160'(last_rdata_i));
    check("stray_hold_d", 160'(o_dcache_rdata), 160'(last_rdata_d));

    // reset in the middle of a D write
    req_d(16'h0040, 1'b0, 1'b1, {4{32'h1111_2222}});
    push_d(16'h0040, 1'b1, {4{32'h1111_2222}});
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!o_l2_write && w < 20);
    check("rst_pre_write", 160'(o_l2_write), 160'(1));
    #2 reset = 1'b1;
    #1;
    check("rst_async_ctl", 160'({o_l2_read, o_l2_write, o_icache_resp, o_dcache_resp}), 160'(0));
    check("rst_async_addr", 160'(o_l2_address), 160'(0));
    check("rst_async_wdata", 160'(o_l2_wdata), 160'(0));
    check("rst_async_rdata", 160'(o_icache_rdata ^ o_dcache_rdata), 160'(0));
    check("rst_async_state", 160'(o_state), 160'(0));
    req_q.delete();
    clear_inputs();
    model_last_d = 1'b0; model_wdata = '0; last_rdata_i = '0; last_rdata_d = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_no_dresp", 160'(o_dcache_resp), 160'(0));
    end
    req_i(16'h0ABC);
    push_i(16'h0ABC);
    serve(1'b0, 2, rand_line(), 1);

    // random mix of single and conflicting requests
    for (int n = 0; n < 10; n++) begin
      int mode;
      logic [AW-1:0] ai, ad;
      logic wr, rd;
      logic [LW-1:0] wd;
      mode = $urandom_range(0, 2);
      ai = AW'($urandom_range(0, 16'hFFFF));
      ad = AW'($urandom_range(0, 16'hFFFF));
      wr = 1'($urandom_range(0, 1));
      rd = !wr || 1'($urandom_range(0, 1));
      wd = rand_line();
      if (mode == 0) begin
        req_i(ai);
        push_i(ai);
        serve(1'b0, $urandom_range(1, 4), rand_line(), 1);
      end else if (mode == 1) begin
        req_d(ad, rd, wr, wd);
        push_d(ad, wr, wd);
        serve(1'b1, $urandom_range(1, 4), rand_line(), 1);
      end else begin
        conflict(ai, ad, rd, wr, wd, $urandom_range(1, 4));
      end
    end

    // fixed-priority instance: D wins three back-to-back conflicts, I served after
    reset = 1'b1;
    clear_inputs();
    sel = 1'b1;
    model_last_d = 1'b0; model_wdata = '0;
    @(negedge clk);
    reset = 1'b0;
    check("fp_rst_state", 160'(o_state), 160'(0));
    req_i(16'h5550);
    for (int k = 0; k < 3; k++) begin
      req_d(AW'(16'h6000 + k * 16), 1'b1, 1'b0, '0);
      push_d(AW'(16'h6000 + k * 16), 1'b0, '0);
      serve(1'b1, 1 + k, rand_line(), 1);
    end
    push_i(16'h5550);
    serve(1'b0, 2, rand_line(), 1);
    conflict(16'h7774, 16'h8881, 1'b0, 1'b1, rand_line(), 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
